// File: rtl/ps2_kbd_rx_if.sv
// ps2_kbd_rx_if: CPU-side PIA keyboard register bus.
//   enable    bus clock-enable strobe (CPU -> keyboard)
//   r_en      read strobe (CPU -> keyboard)
//   address   0 = KBD data, 1 = KBDCR status (CPU -> keyboard)
//   dout      read data, combinational on address (keyboard -> CPU)
//   key_ready at least one character buffered (keyboard -> CPU)
interface ps2_kbd_rx_if;
   logic       enable;
   logic       r_en;
   logic       address;
   logic [7:0] dout;
   logic       key_ready;
   modport master (output enable, r_en, address, input dout, key_ready);
   modport slave (input enable, r_en, address, output dout, key_ready);
endinterface

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 set-2 keyboard receiver translating keystrokes to Apple-1 ASCII for PIA reads.
//   clk25   25 MHz system clock
//   rst_n   synchronous active-low reset
//   ps2_clk raw asynchronous PS/2 clock
//   ps2_din raw asynchronous PS/2 data
//   bus     ps2_kbd_rx_if.slave: enable, r_en, address in; dout, key_ready out
// Build option: KBD_FIFO_EN selects a 4-entry FIFO instead of a single overwriting holding register.
module ps2_kbd_rx #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FILTER_LEN     = 8
) (
   input logic          clk25,
   input logic          rst_n,
   input logic          ps2_clk,
   input logic          ps2_din,
   ps2_kbd_rx_if.slave  bus
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int FW = $clog2(FILTER_LEN + 1);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   logic [1:0]    clk_s, din_s;
   logic          flt, flt_d, sample;
   logic [FW-1:0] flt_cnt;
   state_t        state, state_n;
   logic [2:0]    bcnt;
   logic [7:0]    sh, byte_q, idx, head;
   logic          par, timeout, frame_ok, byte_vld;
   logic [TW-1:0] to_cnt;
   logic          shift, brk, ext, is_shift, idx_vld;
   logic [6:0]    chr;
   logic          push, pop, rd_seen, key_ready;

   function automatic logic [6:0] xlat(input logic [7:0] i);
      logic s;
      s = i[7];
      case (i[6:0])
         7'h1C: xlat = 7'h41;  7'h32: xlat = 7'h42;  7'h21: xlat = 7'h43;  7'h23: xlat = 7'h44;
         7'h24: xlat = 7'h45;  7'h2B: xlat = 7'h46;  7'h34: xlat = 7'h47;  7'h33: xlat = 7'h48;
         7'h43: xlat = 7'h49;  7'h3B: xlat = 7'h4A;  7'h42: xlat = 7'h4B;  7'h4B: xlat = 7'h4C;
         7'h3A: xlat = 7'h4D;  7'h31: xlat = 7'h4E;  7'h44: xlat = 7'h4F;  7'h4D: xlat = 7'h50;
         7'h15: xlat = 7'h51;  7'h2D: xlat = 7'h52;  7'h1B: xlat = 7'h53;  7'h2C: xlat = 7'h54;
         7'h3C: xlat = 7'h55;  7'h2A: xlat = 7'h56;  7'h1D: xlat = 7'h57;  7'h22: xlat = 7'h58;
         7'h35: xlat = 7'h59;  7'h1A: xlat = 7'h5A;
         7'h16: xlat = s ? 7'h21 : 7'h31;
         7'h1E: xlat = s ? 7'h40 : 7'h32;
         7'h26: xlat = s ? 7'h23 : 7'h33;
         7'h25: xlat = s ? 7'h24 : 7'h34;
         7'h2E: xlat = s ? 7'h25 : 7'h35;
         7'h36: xlat = s ? 7'h5E : 7'h36;
         7'h3D: xlat = s ? 7'h26 : 7'h37;
         7'h3E: xlat = s ? 7'h2A : 7'h38;
         7'h46: xlat = s ? 7'h28 : 7'h39;
         7'h45: xlat = s ? 7'h29 : 7'h30;
         7'h0E: xlat = s ? 7'h7E : 7'h60;
         7'h4E: xlat = s ? 7'h5F : 7'h2D;
         7'h55: xlat = s ? 7'h2B : 7'h3D;
         7'h54: xlat = s ? 7'h7B : 7'h5B;
         7'h5B: xlat = s ? 7'h7D : 7'h5D;
         7'h5D: xlat = s ? 7'h7C : 7'h5C;
         7'h4C: xlat = s ? 7'h3A : 7'h3B;
         7'h52: xlat = s ? 7'h22 : 7'h27;
         7'h41: xlat = s ? 7'h3C : 7'h2C;
         7'h49: xlat = s ? 7'h3E : 7'h2E;
         7'h4A: xlat = s ? 7'h3F : 7'h2F;
         7'h29: xlat = 7'h20;
         7'h5A: xlat = 7'h0D;
         7'h66: xlat = 7'h5F;
         7'h76: xlat = 7'h1B;
         default: xlat = 7'h00;
      endcase
   endfunction

   // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
   always_ff @(posedge clk25) begin
      if (!rst_n) begin
         clk_s   <= 2'b11;
         din_s   <= 2'b11;
         flt     <= 1'b1;
         flt_d   <= 1'b1;
         flt_cnt <= '0;
      end else begin
         clk_s <= {clk_s[0], ps2_clk};
         din_s <= {din_s[0], ps2_din};
         flt_d <= flt;
         if (clk_s[1] == flt) flt_cnt <= '0;
         else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            flt     <= clk_s[1];
            flt_cnt <= '0;
         end else flt_cnt <= flt_cnt + 1'b1;
      end
   end

   assign sample  = flt_d & ~flt;
   assign timeout = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES));

   always_comb begin
      state_n  = timeout ? IDLE :
                 !sample ? state :
                 state == IDLE ? (din_s[1] ? IDLE : DATA) :
                 state == DATA ? (bcnt == 3'd7 ? PARITY : DATA) :
                 state == PARITY ? STOP : IDLE;
      // odd parity over data plus parity bit, stop bit must be 1
      frame_ok = !timeout && sample && state == STOP && din_s[1] && ^{par, sh};
   end

   always_ff @(posedge clk25) begin
      if (!rst_n) begin
         state    <= IDLE;
         bcnt     <= '0;
         sh       <= '0;
         par      <= 1'b0;
         to_cnt   <= '0;
         byte_vld <= 1'b0;
         byte_q   <= '0;
      end else begin
         state    <= state_n;
         to_cnt   <= sample ? '0 : (to_cnt == TW'(TIMEOUT_CYCLES)) ? to_cnt : to_cnt + 1'b1;
         byte_vld <= frame_ok;
         if (frame_ok) byte_q <= sh;
         if (sample && state == IDLE) bcnt <= '0;
         if (sample && state == DATA) begin
            sh   <= {din_s[1], sh[7:1]};
            bcnt <= bcnt + 1'b1;
         end
         if (sample && state == PARITY) par <= din_s[1];
      end
   end

   assign is_shift = (byte_q == 8'h12) || (byte_q == 8'h59);

   always_ff @(posedge clk25) begin
      if (!rst_n) begin
         shift   <= 1'b0;
         brk     <= 1'b0;
         ext     <= 1'b0;
         idx_vld <= 1'b0;
         idx     <= '0;
      end else begin
         idx_vld <= 1'b0;
         if (byte_vld) begin
            if (byte_q == 8'hF0) brk <= 1'b1;
            else if (byte_q == 8'hE0) ext <= 1'b1;
            else if (brk) begin
               if (is_shift) shift <= 1'b0;
               brk <= 1'b0;
               ext <= 1'b0;
            end else if (ext) ext <= 1'b0;
            else if (is_shift) shift <= 1'b1;
            else if (!byte_q[7]) begin
               idx_vld <= 1'b1;
               idx     <= {shift, byte_q[6:0]};
            end
         end
      end
   end

   assign chr  = xlat(idx);
   assign push = idx_vld && (chr != 7'h00);
   assign pop  = bus.enable & bus.r_en & ~bus.address & ~rd_seen & key_ready;

`ifdef KBD_FIFO_EN
   logic [7:0] mem [4];
   logic [7:0] last;
   logic [1:0] wp, rp;
   logic [2:0] cnt;
   logic       wr;
   assign wr        = push && (cnt != 3'd4);
   assign key_ready = cnt != 3'd0;
   assign head      = key_ready ? mem[rp] : last;
   always_ff @(posedge clk25) if (wr) mem[wp] <= {1'b1, chr};
   always_ff @(posedge clk25) begin
      if (!rst_n) begin
         wp   <= '0;
         rp   <= '0;
         cnt  <= '0;
         last <= '0;
      end else begin
         if (wr) wp <= wp + 1'b1;
         if (pop) begin
            rp   <= rp + 1'b1;
            last <= mem[rp];
         end
         cnt <= cnt + 3'(wr) - 3'(pop);
      end
   end
`else
   logic [7:0] hold;
   logic       valid;
   assign key_ready = valid;
   assign head      = hold;
   always_ff @(posedge clk25) begin
      if (!rst_n) begin
         hold  <= '0;
         valid <= 1'b0;
      end else begin
         if (push) hold <= {1'b1, chr};
         valid <= push | (valid & ~pop);
      end
   end
`endif

   // a held strobe pops once; rearm only after both strobes drop
   always_ff @(posedge clk25) begin
      if (!rst_n) rd_seen <= 1'b0;
      else rd_seen <= pop ? 1'b1 : (~bus.enable & ~bus.r_en) ? 1'b0 : rd_seen;
   end

   assign bus.key_ready = key_ready;
   assign bus.dout      = bus.address ? {key_ready, 7'b0} : head;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: scoreboard bench driving PS/2 frames and PIA reads into ps2_kbd_rx.
module tb_ps2_kbd_rx;
   logic clk25 = 1'b0;
   logic rst_n = 1'b0;
   logic ps2_clk = 1'b1;
   logic ps2_din = 1'b1;
   int errors = 0;
   int checks = 0;
   logic [7:0] q[$];

   ps2_kbd_rx_if bus();
   ps2_kbd_rx #(.TIMEOUT_CYCLES(2000), .FILTER_LEN(8)) dut (
      .clk25(clk25), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_din(ps2_din), .bus(bus));

   always #20 clk25 = ~clk25;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic expect_char(input logic [7:0] c);
`ifdef KBD_FIFO_EN
      if (q.size() < 4) q.push_back(c);
`else
      q.delete();
      q.push_back(c);
`endif
   endtask

   task automatic send_bit(input logic b);
      ps2_din = b;
      repeat (10) @(negedge clk25);
      ps2_clk = 1'b0;
      repeat (20) @(negedge clk25);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk25);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(~^b ^ bad_par);
      send_bit(1'b1);
      repeat (10) @(negedge clk25);
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (bus.key_ready) ok = 1'b1;
         else @(negedge clk25);
      end
   endtask

   task automatic read0(output logic [7:0] d);
      bus.address = 1'b0;
      bus.enable  = 1'b1;
      bus.r_en    = 1'b1;
      #1 d = bus.dout;
      @(negedge clk25);
      bus.enable = 1'b0;
      bus.r_en   = 1'b0;
      @(negedge clk25);
   endtask

   task automatic drain(input string tag);
      bit ok;
      logic [7:0] d;
      while (q.size() > 0) begin
         wait_ready(ok);
         if (!ok) begin
            check({tag, "_wait"}, {7'd0, bus.key_ready}, 8'd1);
            q.delete();
         end else begin
            read0(d);
            check(tag, d, q.pop_front());
         end
      end
      check({tag, "_empty"}, {7'd0, bus.key_ready}, 8'd0);
   endtask

   initial begin
      bit ok;
      bus.enable  = 1'b0;
      bus.r_en    = 1'b0;
      bus.address = 1'b0;
      repeat (4) @(negedge clk25);
      check("rst_kr", {7'd0, bus.key_ready}, 8'd0);
      #1 check("rst_dout0", bus.dout, 8'h00);
      bus.address = 1'b1;
      #1 check("rst_dout1", bus.dout, 8'h00);
      bus.address = 1'b0;
      rst_n = 1'b1;
      repeat (4) @(negedge clk25);

      send_frame(8'h1C, 1'b0);
      expect_char(8'hC1);
      wait_ready(ok);
      bus.address = 1'b1;
      #1 check("kbdcr", bus.dout, 8'h80);
      bus.address = 1'b0;
      drain("key_a");

      send_frame(8'h12, 1'b0);
      send_frame(8'h16, 1'b0);
      expect_char(8'hA1);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h16, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h12, 1'b0);
      send_frame(8'h16, 1'b0);
      expect_char(8'hB1);
      drain("shift");

      send_frame(8'h1C, 1'b1);
      repeat (20) @(negedge clk25);
      check("bad_par_kr", {7'd0, bus.key_ready}, 8'd0);
      send_frame(8'h5A, 1'b0);
      expect_char(8'h8D);
      drain("ret");

      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      repeat (2400) @(negedge clk25);
      send_frame(8'h29, 1'b0);
      expect_char(8'hA0);
      drain("timeout");

      send_frame(8'hE0, 1'b0);
      send_frame(8'h75, 1'b0);
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h75, 1'b0);
      send_frame(8'h12, 1'b0);
      send_frame(8'h52, 1'b0);
      expect_char(8'hA2);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h12, 1'b0);
      send_frame(8'h4E, 1'b0);
      expect_char(8'hAD);
      send_frame(8'h66, 1'b0);
      expect_char(8'hDF);
      drain("ext_punct");

      send_frame(8'h1C, 1'b0);
      expect_char(8'hC1);
      send_frame(8'h32, 1'b0);
      expect_char(8'hC2);
      send_frame(8'h21, 1'b0);
      expect_char(8'hC3);
      send_frame(8'h23, 1'b0);
      expect_char(8'hC4);
      send_frame(8'h24, 1'b0);
      expect_char(8'hC5);
      drain("overflow");

      send_frame(8'h1C, 1'b0);
      expect_char(8'hC1);
      send_frame(8'h32, 1'b0);
      expect_char(8'hC2);
      wait_ready(ok);
      if (!ok) check("hold_wait", {7'd0, bus.key_ready}, 8'd1);
      else begin
         bus.address = 1'b0;
         bus.enable  = 1'b1;
         bus.r_en    = 1'b1;
         #1 check("hold_first", bus.dout, q.pop_front());
         repeat (10) @(negedge clk25);
         bus.enable = 1'b0;
         bus.r_en   = 1'b0;
         @(negedge clk25);
      end
      drain("hold");

      send_frame(8'h16, 1'b0);
      check("pre_rst_kr", {7'd0, bus.key_ready}, 8'd1);
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      rst_n = 1'b0;
      @(posedge clk25);
      #1 check("mid_rst_kr", {7'd0, bus.key_ready}, 8'd0);
      check("mid_rst_dout0", bus.dout, 8'h00);
      bus.address = 1'b1;
      #1 check("mid_rst_dout1", bus.dout, 8'h00);
      bus.address = 1'b0;
      @(negedge clk25);
      rst_n = 1'b1;
      repeat (4) @(negedge clk25);
      send_frame(8'h76, 1'b0);
      expect_char(8'h9B);
      drain("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
